// File: rtl/store_data_unit.sv
// Store data unit: aligns rs2 data into byte lanes for SB/SH/SW and drives the data-memory
// write port with hold-until-ack and a timeout. Optional macro STORE_MISALIGN_TRAP_EN traps misaligned SH/SW.
module store_data_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stReq,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [31:0]       dataIn,
  output logic              stReady,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWdata,
  output logic [3:0]        memBe,
  input  logic              memAck
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned TO_LAST = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam logic        TIMEOUT_EN = (ACK_TIMEOUT != 0);

`ifdef STORE_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } wr_beat_t;

  logic [0:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_beat_t         beat_q, beat_d;

  wr_beat_t   beat_c;
  logic [1:0] lane_c;
  logic       legal_c;
  logic       misalign_c;
  logic       accept_c;

  // Lane formatting of the incoming request
  always_comb begin
    lane_c       = addrIn[1:0];
    beat_c.addr  = {addrIn[ADDR_W-1:2], 2'b00};
    beat_c.wdata = dataIn;
    beat_c.be    = 4'b0000;
    legal_c      = 1'b0;
    misalign_c   = 1'b0;
    case (funct3)
      F3_SB: begin
        beat_c.wdata = {4{dataIn[7:0]}};
        beat_c.be    = 4'b0001 << lane_c;
        legal_c      = 1'b1;
      end
      F3_SH: begin
        beat_c.wdata = {2{dataIn[15:0]}};
        beat_c.be    = lane_c[1] ? 4'b1100 : 4'b0011;
        legal_c      = 1'b1;
        misalign_c   = lane_c[0];
      end
      F3_SW: begin
        beat_c.wdata = dataIn;
        beat_c.be    = 4'b1111;
        legal_c      = 1'b1;
        misalign_c   = |lane_c;
      end
      default: ;
    endcase
    accept_c = legal_c & ~(TRAP_EN & misalign_c);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = we_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (stReq) begin
          if (accept_c) begin
            beat_d  = beat_c;
            cnt_d   = '0;
            we_d    = 1'b1;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (memAck) begin
          done_d  = 1'b1;
          we_d    = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_W'(TO_LAST))) begin
          err_d   = 1'b1;
          we_d    = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  assign stReady  = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign memWe    = we_q;
  assign memAddr  = beat_q.addr;
  assign memWdata = beat_q.wdata;
  assign memBe    = beat_q.be;

endmodule

// File: tb/tb_store_data_unit.sv
// Randomized bench for store_data_unit against a byte-lane reference model.
// Model follows STORE_MISALIGN_TRAP_EN the same way the design build does.
module tb_store_data_unit;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stReq;
  logic [2:0]  funct3;
  logic [31:0] addrIn;
  logic [31:0] dataIn;
  logic        stReady, busy, done, err, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memAck;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  store_data_unit #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .stReq(stReq), .funct3(funct3), .addrIn(addrIn),
    .dataIn(dataIn), .stReady(stReady), .busy(busy), .done(done), .err(err),
    .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memAck(memAck)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string ctx, input logic exp_we, input logic exp_done,
                          input logic exp_err, input logic exp_rdy);
    chk({ctx, "_we"},    32'(memWe),    32'(exp_we));
    chk({ctx, "_done"},  32'(done),     32'(exp_done));
    chk({ctx, "_err"},   32'(err),      32'(exp_err));
    chk({ctx, "_ready"}, 32'(stReady),  32'(exp_rdy));
    chk({ctx, "_busy"},  32'(busy),     32'(!exp_rdy));
    chk({ctx, "_addr"},  memAddr,       last_addr);
    chk({ctx, "_wdata"}, memWdata,      last_wdata);
    chk({ctx, "_be"},    32'(memBe),    32'(last_be));
  endtask

  // Reference: access size in bytes, lanes covered at the (aligned) offset, data replicated per size
  function automatic void predict(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                  output bit ok, output logic [31:0] wa, output logic [31:0] wd,
                                  output logic [3:0] be);
    int unsigned size, off, base;
    ok   = (f3 <= 3'd2);
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    off  = int'(a % 4);
`ifdef STORE_MISALIGN_TRAP_EN
    if (ok && (off % size) != 0) ok = 1'b0;
`endif
    base = (off / size) * size;
    be   = 4'(((1 << size) - 1) << base);
    wa   = a & 32'hFFFF_FFFC;
    wd   = '0;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % size) +: 8];
  endfunction

  // ack_at: memWe cycle index (0 = first) on which memAck is raised; <0 or >=TO means never
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int ack_at);
    bit ok, acked;
    logic [31:0] wa, wd;
    logic [3:0]  be;
    int n_we;
    predict(f3, a, d, ok, wa, wd, be);
    stReq = 1'b1; funct3 = f3; addrIn = a; dataIn = d; memAck = 1'b0;
    @(negedge CLK);
    stReq = 1'b0; funct3 = 3'($urandom); addrIn = $urandom; dataIn = $urandom;
    if (!ok) begin
      chk_outs("rej", 1'b0, 1'b0, 1'b1, 1'b1);
      return;
    end
    last_addr = wa; last_wdata = wd; last_be = be;
    acked = (ack_at >= 0) && (ack_at < int'(TO));
    n_we  = acked ? ack_at + 1 : int'(TO);
    for (int k = 0; k < n_we; k++) begin
      chk_outs("wr", 1'b1, 1'b0, 1'b0, 1'b0);
      memAck = (k == ack_at);
      @(negedge CLK);
      memAck = 1'b0;
    end
    chk_outs(acked ? "ack" : "tmo", 1'b0, acked, !acked, 1'b1);
  endtask

  task automatic idle_cycle();
    stReq  = 1'b0;
    memAck = 1'($urandom);
    @(negedge CLK);
    memAck = 1'b0;
    chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_mid_write();
    stReq = 1'b1; funct3 = 3'b010; addrIn = 32'h5000; dataIn = 32'hCAFEF00D; memAck = 1'b0;
    @(negedge CLK);
    stReq = 1'b0;
    last_addr = 32'h5000; last_wdata = 32'hCAFEF00D; last_be = 4'hF;
    chk_outs("rw1", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk_outs("rw2", 1'b1, 1'b0, 1'b0, 1'b0);
    #1 RST = 1'b1;
    #1;
    last_addr = '0; last_wdata = '0; last_be = '0;
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) idle_cycle();
  endtask

  initial begin
    int ack_at;
    logic [2:0] f3;
    RST = 1'b1; stReq = 1'b0; funct3 = '0; addrIn = '0; dataIn = '0; memAck = 1'b0;
    last_addr = '0; last_wdata = '0; last_be = '0;
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle_cycle();

    do_store(3'b000, 32'h1003, 32'hAABBCCDD, 1);
    chk("sb_addr", memAddr, 32'h1000);
    chk("sb_be", 32'(memBe), 32'h8);
    chk("sb_wdata", memWdata, 32'hDDDDDDDD);
    idle_cycle();

    do_store(3'b001, 32'h2002, 32'h12345678, 0);
    chk("sh_be", 32'(memBe), 32'hC);
    chk("sh_wdata", memWdata, 32'h56785678);
    idle_cycle();

    do_store(3'b010, 32'h3001, 32'h0BADBEEF, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("sw_mis_addr_hold", memAddr, 32'h2000);
`else
    chk("sw_mis_addr", memAddr, 32'h3000);
    chk("sw_mis_be", 32'(memBe), 32'hF);
    chk("sw_mis_wdata", memWdata, 32'h0BADBEEF);
`endif
    idle_cycle();

    do_store(3'b011, 32'h1234, 32'h11111111, 0);
    idle_cycle();

    do_store(3'b010, 32'h4000, 32'h55AA55AA, -1);
    idle_cycle();

    reset_mid_write();

    for (int it = 0; it < 300; it++) begin
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      ack_at = int'($urandom_range(0, 6)) - 1;
      do_store(f3, $urandom, $urandom, ack_at);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_data_unit.md
# store_data_unit

Store-side counterpart of the memory data register. It accepts a store request from the multi-cycle core's control path (address, rs2 value, funct3), aligns the data and builds byte enables for SB/SH/SW, and drives the data-memory write port with a hold-until-acknowledge handshake and a timeout. It sits between the datapath (ALU result / register file read port B) and the data memory write interface, alongside the load path's data register.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- ACK_TIMEOUT, 255, max cycles memWe may wait for memAck; 0 disables timeout

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- stReq  in  1  store request, sampled only when stReady=1
- funct3  in  3  000=SB, 001=SH, 010=SW; others illegal
- addrIn  in  ADDR_W  byte address of store
- dataIn  in  32  store source (rs2)
- stReady  out  1  unit idle, can accept stReq
- busy  out  1  store in flight (inverse of stReady)
- done  out  1  one-cycle pulse: store acknowledged
- err  out  1  one-cycle pulse: illegal funct3, misalign (if enabled), or timeout
- memWe  out  1  write strobe, held until memAck
- memAddr  out  ADDR_W  word-aligned address {addrIn[ADDR_W-1:2],2'b00}
- memWdata  out  32  lane-replicated write data
- memBe  out  4  byte enables, bit i = byte lane i (little-endian)
- memAck  in  1  memory write accepted

## Operation
- States: IDLE, WRITE. stReady=1 and busy=0 only in IDLE.
- IDLE, stReq=1, legal request: register memAddr/memWdata/memBe, clear timeout counter, -> WRITE.
- IDLE, stReq=1, illegal request: no write, err=1 next cycle, stay IDLE.
- IDLE, stReq=0: outputs hold; memAck ignored.
- WRITE: memWe=1, memAddr/memWdata/memBe stable. memAck=1 -> IDLE, done=1 next cycle. Otherwise counter+1; when counter reaches ACK_TIMEOUT (nonzero) -> IDLE, err=1 next cycle, no done.
- Lane formatting (a = addrIn[1:0]):
  - SB: memWdata={4{dataIn[7:0]}}, memBe=4'b0001<<a
  - SH: memWdata={2{dataIn[15:0]}}, memBe = a[1] ? 4'b1100 : 4'b0011
  - SW: memWdata=dataIn, memBe=4'b1111
- Misalign: SH with a[0]=1; SW with a!=0. Handling per Configuration.
- memWdata/memBe/memAddr are registered; in IDLE they hold last values; memWe is the only qualifier.
- done and err never asserted in the same cycle.

## Timing
- Reset (async): state=IDLE, memWe=0, memAddr=0, memWdata=0, memBe=0, done=0, err=0, counter=0; stReady=1, busy=0 while and after RST is high.
- stReq accepted at edge N -> memWe=1 from cycle N+1.
- memAck sampled at edge M while memWe=1 -> memWe=0, done=1 in cycle M+1, stReady=1 in M+1; next stReq accepted at edge M+1 earliest, giving one idle cycle between strobes.
- memAck in the first memWe cycle is legal: minimum store = 2 cycles request-to-done.
- Timeout: memWe high for exactly ACK_TIMEOUT cycles without ack -> low in the next cycle, with err=1.
- RST mid-WRITE: memWe drops immediately, no done/err, store is lost.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: misaligned SH/SW not written; err=1 the cycle after stReq, stays IDLE.
- Not defined: no trap; SH ignores a[0], SW ignores a[1:0]; store performed at the aligned lanes; err only for illegal funct3 and timeout.

## Test plan
- SB addr=0x1003, dataIn=0xAABBCCDD, ack on 2nd memWe cycle -> memAddr=0x1000, memBe=1000, memWdata=0xDDDDDDDD, done 1 cycle after ack.
- SH addr=0x2002, dataIn=0x12345678, ack same cycle as first memWe -> memBe=1100, memWdata=0x56785678, done at request+2.
- SW addr=0x3001 -> with macro: err pulse, memWe never high; without: memAddr=0x3000, memBe=1111, memWdata=dataIn.
- funct3=011 -> err pulse next cycle, memWe stays 0, stReady stays 1.
- ACK_TIMEOUT=4, SW, no ack -> memWe high exactly 4 cycles, then err=1, done=0, back to IDLE.
- RST asserted in 2nd WRITE cycle -> memWe=0 same cycle, all outputs zero, stReady=1, no done/err after release.
